// File: rtl/dvp_tx.sv
// dvp_tx: DVP camera-side transmitter that serialises pixels into vsync/href/8-bit byte lanes, MSB byte first.
// Latency: a pixel accepted in cycle t shows its first byte on data_o in cycle t+1. Frame timing is fixed by the parameters.
// Backpressure: none. A pixel is pulled only at fetch cycles. A missing pixel is sent as zero bytes and flagged on underflow_o.
// Optional macro DVP_TX_TEST_PATTERN_EN adds pattern_en_i and an internal 8-bar colour-bar generator.
module dvp_tx #(
    parameter int    WIDTH       = 1280,
    parameter int    HEIGHT      = 720,
    parameter string DATA_FORMAT = "RGB888",
    parameter int    VSYNC_LEN   = 8,
    parameter int    VBP         = 16,
    parameter int    HBLANK      = 32,
    parameter int    VFP         = 16,
    localparam int   BYTES       = (DATA_FORMAT == "RGB888") ? 3 : 2
) (
    input  logic               pclk_i,
    input  logic               rst_n_i,
    input  logic               enable_i,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic               pattern_en_i,
`endif
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [8*BYTES-1:0] in_data_i,
    output logic               vsync_o,
    output logic               href_o,
    output logic [7:0]         data_o,
    output logic               frame_done_o,
    output logic               underflow_o,
    output logic               busy_o
);

    localparam int PW   = 8 * BYTES;
    localparam int M1   = (WIDTH > VSYNC_LEN) ? WIDTH : VSYNC_LEN;
    localparam int M2   = (VBP > HBLANK) ? VBP : HBLANK;
    localparam int M3   = (M1 > M2) ? M1 : M2;
    localparam int CMAX = (M3 > VFP) ? M3 : VFP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int LW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BW   = $clog2(BYTES);

    localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_LEN - 1);
    localparam logic [CW-1:0] VBP_LAST = CW'(VBP - 1);
    localparam logic [CW-1:0] HB_LAST  = CW'(HBLANK - 1);
    localparam logic [CW-1:0] VFP_LAST = CW'(VFP - 1);
    localparam logic [CW-1:0] W_LAST   = CW'(WIDTH - 1);
    localparam logic [LW-1:0] H_LAST   = LW'(HEIGHT - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK, S_VFP} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;        // cycles within a phase; pixel index during ACTIVE
    logic [LW-1:0]  line_q;
    logic [BW-1:0]  byte_q;       // byte index within the current pixel
    logic [PW-1:0]  sh_q;
    logic           vsync_q, href_q, frame_done_q, underflow_q;
    logic [7:0]     data_q;
    logic           fetch;
    logic [PW-1:0]  src_pix;
    logic           src_ok;

    // A fetch happens in the cycle just before a pixel's first byte goes out.
    always_comb begin
        fetch = 1'b0;
        case (state_q)
            S_VBP:    fetch = (cnt_q == VBP_LAST);
            S_HBLANK: fetch = (cnt_q == HB_LAST);
            S_ACTIVE: fetch = (byte_q == B_LAST) && (cnt_q != W_LAST);
            default:  fetch = 1'b0;
        endcase
    end

`ifdef DVP_TX_TEST_PATTERN_EN
    logic          pat_q;
    logic [CW-1:0] nxt_hpix;

    function automatic logic [PW-1:0] bar_pix(input logic [CW-1:0] hpix);
        int unsigned h;
        int unsigned bar;
        logic        r, g, b;
        h   = 32'(hpix);
        bar = (h * 8) / WIDTH;
        r   = bar[2];
        g   = bar[1];
        b   = bar[0];
        if (BYTES == 3) bar_pix = PW'({{8{r}}, {8{g}}, {8{b}}});
        else            bar_pix = PW'({{5{r}}, {6{g}}, {5{b}}});
    endfunction

    assign nxt_hpix   = (state_q == S_ACTIVE) ? cnt_q + CW'(1) : '0;
    assign src_pix    = pat_q ? bar_pix(nxt_hpix) : in_data_i;
    assign src_ok     = pat_q | in_valid_i;
    assign in_ready_o = fetch & ~pat_q;
`else
    assign src_pix    = in_data_i;
    assign src_ok     = in_valid_i;
    assign in_ready_o = fetch;
`endif

    assign busy_o       = (state_q != S_IDLE);
    assign vsync_o      = vsync_q;
    assign href_o       = href_q;
    assign data_o       = data_q;
    assign frame_done_o = frame_done_q;
    assign underflow_o  = underflow_q;

    // Frame FSM: phase counters, byte shifter and all registered DVP outputs.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            byte_q       <= '0;
            sh_q         <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
`ifdef DVP_TX_TEST_PATTERN_EN
            pat_q        <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            // Load the next pixel; a missing one becomes zero bytes without consuming a word.
            if (fetch) begin
                if (src_ok) begin
                    data_q <= src_pix[PW-1 -: 8];
                    sh_q   <= src_pix << 8;
                end else begin
                    data_q      <= '0;
                    sh_q        <= '0;
                    underflow_q <= 1'b1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_q <= S_VSYNC;
                        cnt_q   <= '0;
                        vsync_q <= 1'b1;
`ifdef DVP_TX_TEST_PATTERN_EN
                        pat_q   <= pattern_en_i;
`endif
                    end
                end
                S_VSYNC: begin
                    if (cnt_q == VS_LAST) begin
                        state_q <= S_VBP;
                        cnt_q   <= '0;
                        vsync_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_VBP: begin
                    if (cnt_q == VBP_LAST) begin
                        state_q <= S_ACTIVE;
                        cnt_q   <= '0;
                        byte_q  <= '0;
                        href_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_ACTIVE: begin
                    if (byte_q == B_LAST) begin
                        byte_q <= '0;
                        if (cnt_q == W_LAST) begin
                            cnt_q  <= '0;
                            href_q <= 1'b0;
                            data_q <= '0;
                            if (line_q == H_LAST) begin
                                state_q      <= S_VFP;
                                frame_done_q <= (VFP == 1);
                            end else begin
                                state_q <= S_HBLANK;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else begin
                        byte_q <= byte_q + BW'(1);
                        data_q <= sh_q[PW-1 -: 8];
                        sh_q   <= sh_q << 8;
                    end
                end
                S_HBLANK: begin
                    if (cnt_q == HB_LAST) begin
                        state_q <= S_ACTIVE;
                        cnt_q   <= '0;
                        byte_q  <= '0;
                        line_q  <= line_q + LW'(1);
                        href_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_VFP: begin
                    if (cnt_q == VFP_LAST) begin
                        cnt_q  <= '0;
                        line_q <= '0;
                        if (enable_i) begin
                            state_q <= S_VSYNC;
                            vsync_q <= 1'b1;
`ifdef DVP_TX_TEST_PATTERN_EN
                            pat_q   <= pattern_en_i;
`endif
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q        <= cnt_q + CW'(1);
                        frame_done_q <= ((cnt_q + CW'(1)) == VFP_LAST);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
